// File: rtl/id_dispatch_queue.sv
// Decode-to-execute instruction queue. It presents the head entry to execute and,
// in parallel, offers that entry to one multi-cycle functional unit.
module id_dispatch_queue #(
   parameter int  DATA_W    = 256,
   parameter int  NUM_UNITS = 3,
   parameter int  DEPTH     = 2,
   localparam int UNIT_W    = $clog2(NUM_UNITS + 1),
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 valid_in,
   output logic                 ready_out,
   input  logic [DATA_W-1:0]    payload_in,
   input  logic [UNIT_W-1:0]    unit_sel_in,
   input  logic                 exc_pend_in,
   input  logic                 serialize_in,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic [DATA_W-1:0]    payload_out,
   output logic                 exc_pend_out,
   output logic [NUM_UNITS-1:0] unit_valid_out,
   input  logic [NUM_UNITS-1:0] unit_ready_in,
   output logic [CNT_W-1:0]     count_out,
   output logic                 serial_busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] payload_mem [DEPTH];
   logic [UNIT_W-1:0] unit_mem [DEPTH];
   logic [DEPTH-1:0]  exc_mem;
   logic [DEPTH-1:0]  ser_mem;
   logic [DEPTH-1:0]  done_mem;
   logic [DEPTH-1:0]  occ;
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [CNT_W-1:0]  count;

   logic              push;
   logic              pop;
   logic              unit_fire;
   logic              not_empty;
   logic [UNIT_W-1:0] unit_sel_norm;
   logic [UNIT_W-1:0] head_unit;
   logic              head_exc;
   logic              head_done;

   // Wraps explicitly, so non-power-of-two depths work
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Selects beyond the last unit mean "no unit"; only reachable if UNIT_W has spare codes
   generate
      if ((2 ** UNIT_W) - 1 > NUM_UNITS) begin : g_norm
         assign unit_sel_norm = (unit_sel_in > UNIT_W'(NUM_UNITS)) ? '0 : unit_sel_in;
      end else begin : g_pass
         assign unit_sel_norm = unit_sel_in;
      end
   endgenerate

   assign not_empty   = (count != '0);
   assign serial_busy = |(occ & ser_mem);
   assign ready_out   = (count < CNT_W'(DEPTH)) && !serial_busy && !flush;
   assign valid_out   = not_empty && !flush;
   assign push        = valid_in && ready_out;
   assign pop         = valid_out && ready_in;

   assign head_unit = unit_mem[head];
   assign head_exc  = exc_mem[head];
   assign head_done = done_mem[head];

   assign payload_out  = not_empty ? payload_mem[head] : '0;
   assign exc_pend_out = not_empty && head_exc;
   assign count_out    = count;

   always_comb begin
      unit_valid_out = '0;
      for (int k = 0; k < NUM_UNITS; k++)
         unit_valid_out[k] = valid_out && !head_exc && !head_done &&
                             (head_unit == UNIT_W'(k + 1));
   end

   assign unit_fire = |(unit_valid_out & unit_ready_in);

   // Payload storage is left unreset; it is masked whenever the queue is empty
   always_ff @(posedge clk) begin
      if (push)
         payload_mem[tail] <= payload_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         occ      <= '0;
         exc_mem  <= '0;
         ser_mem  <= '0;
         done_mem <= '0;
         for (int i = 0; i < DEPTH; i++)
            unit_mem[i] <= '0;
      end else if (flush) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         occ      <= '0;
         done_mem <= '0;
      end else begin
         if (unit_fire)
            done_mem[head] <= 1'b1;
         if (pop) begin
            occ[head] <= 1'b0;
            head      <= next_ptr(head);
         end
         if (push) begin
            occ[tail]      <= 1'b1;
            unit_mem[tail] <= unit_sel_norm;
            exc_mem[tail]  <= exc_pend_in;
            ser_mem[tail]  <= serialize_in;
            done_mem[tail] <= 1'b0;
            tail           <= next_ptr(tail);
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

endmodule

// File: doc/id_dispatch_queue.md
Name: id_dispatch_queue

Overview:
Parametrised successor to the decode-stage output register. It holds up to DEPTH decoded instructions, each with an opaque payload, in a FIFO between decode and execute, and presents the head to the execute stage over a valid/ready handshake. In parallel it dispatches the head to one of NUM_UNITS multi-cycle functional units (mul/div/fpu/...) through independent per-unit handshakes. It adds multi-entry buffering, a generic unit count, and a serialize hold for CSR-type instructions; flush and exception suppression follow the pipeline's existing rules.

Parameters:
DATA_W, 256, payload width in bits (decoded fields, operands, PC, IR; opaque to this block)
NUM_UNITS, 3, number of functional-unit dispatch channels
DEPTH, 2, queue entries (legal range 1..8)
UNIT_W, $clog2(NUM_UNITS+1), width of unit select (derived, not overridden)
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous pipeline flush
valid_in  in  1  decode has an instruction
ready_out  out  1  queue accepts an instruction this cycle
payload_in  in  DATA_W  decoded instruction payload
unit_sel_in  in  UNIT_W  0 = no unit; k = unit k-1; values above NUM_UNITS are treated as 0
exc_pend_in  in  1  instruction carries a pending exception
serialize_in  in  1  instruction is CSR-type and must serialize
valid_out  out  1  head valid to execute stage
ready_in  in  1  execute stage takes the head
payload_out  out  DATA_W  head payload; all zeros when empty
exc_pend_out  out  1  head exception flag; 0 when empty
unit_valid_out  out  NUM_UNITS  per-unit dispatch valid for the head
unit_ready_in  in  NUM_UNITS  per-unit accept
count_out  out  CNT_W  number of occupied entries
serial_busy  out  1  a serialize entry is queued

Behaviour:
- Reset (async) values: count 0, all entries invalid, valid_out 0, payload_out 0, exc_pend_out 0, unit_valid_out 0, serial_busy 0. ready_out is 1 once reset deasserts while flush is low.
- Storage is a circular buffer with head and tail pointers. Pointers wrap from DEPTH-1 to 0 and must be correct for non-power-of-two DEPTH.
- Push happens when valid_in && ready_out && !flush. The entry stores payload, the normalised unit_sel, exc_pend and serialize, plus a unit_done bit cleared to 0.
- ready_out = (count < DEPTH) && !serial_busy && !flush. It does not depend on ready_in, so a full queue refuses a push even in a cycle where it pops.
- Pop happens when valid_out && ready_in. The head entry is freed and its unit_done bit is discarded.
- A simultaneous push and pop (count < DEPTH) leaves count unchanged and both pointers advance.
- Latency: an instruction pushed in cycle N appears on valid_out in cycle N+1 at the earliest. There is no combinational bypass.
- valid_out = (count != 0) && !flush. The flush gating is combinational, so no handshake completes in a flush cycle.
- unit_valid_out[k] = valid_out && head.unit_sel == k+1 && !head.exc_pend && !head.unit_done.
- When unit_valid_out[k] && unit_ready_in[k], set head.unit_done = 1. unit_valid_out[k] then drops the next cycle even if the head is not popped.
- Unit dispatch and main pop are independent. Popping the head clears its pending dispatch, matching the existing pipeline rule that execute handoff supersedes unit handshakes. A unit accept and a pop in the same cycle are both legal.
- Entries with exc_pend = 1 never raise unit_valid_out and never block on units.
- serial_busy = OR over occupied entries of serialize. While it is high, no further pushes are accepted. It clears on the cycle after the serialize entry pops.
- Flush (priority below reset, above everything else): at the clock edge, count becomes 0, pointers go to 0, all unit_done bits clear, and serial_busy clears. A push in the flush cycle is discarded.
- Reset asserted mid-operation clears everything asynchronously. No partial handshake survives.
- unit_ready_in bits for units with no matching head request are ignored.

Test Plan:
- Reset, then push A (unit_sel=0) → valid_out=1 the next cycle, payload_out=A, count_out=1, unit_valid_out=000. Pop with ready_in=1 → count_out=0, payload_out=0.
- DEPTH=2, ready_in=0: push A, B, then offer C → ready_out=0 when count=2, C not accepted. Raise ready_in with C still offered → A pops, ready_out=1 the next cycle, C enters; order out is A, B, C.
- Head with unit_sel=2, unit_ready_in[1]=0 for 3 cycles, then 1 → unit_valid_out=010 for 4 cycles, then 000 while the head stays (ready_in=0); a later pop yields no re-dispatch.
- Head with unit_sel=3 and exc_pend=1 → unit_valid_out=000 throughout, exc_pend_out=1, pop proceeds normally.
- Push S (serialize=1) with valid_in held high and D behind it → ready_out=0 and serial_busy=1 until S pops; D accepted the cycle after the pop.
- Queue holding 2 entries, one mid-dispatch; assert flush with valid_in=1 → valid_out=0 and unit_valid_out=0 in the flush cycle, count_out=0 after it, the pushed entry is lost, and ready_out=1 the following cycle.
